serial_add_ctrl: RTL and testbench

//   Sequences one 1-bit full-adder cell across WIDTH-bit operands, LSB first, one bit per clock.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/serial_add_ctrl_fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach width-1; never narrower than 1 bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder: the single arithmetic cell reused every bit-time.
module fa_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = x_i ^ y_i ^ z_i;
  assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through one shared fa_cell.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' input that turns the op into a - b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Sources hold valid and data stable until accepted; ready never depends on valid.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, out_valid_q, in_ready_q, busy_q;

  logic [WIDTH-1:0] b_ld_d;
  logic             carry_ld_d;
  logic             fa_s, fa_c;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as a + ~b + 1; cout then reads as "no borrow".
  assign b_ld_d     = sub ? ~b : b;
  assign carry_ld_d = sub ? 1'b1 : cin;
`else
  assign b_ld_d     = b;
  assign carry_ld_d = cin;
`endif

  fa_cell u_fa (
    .x_i (a_sh_q[0]),
    .y_i (b_sh_q[0]),
    .z_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b_ld_d;
            carry_q    <= carry_ld_d;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_sh_q <= {fa_s, sum_sh_q[WIDTH-1:1]};
          carry_q  <= fa_c;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          // The last bit lands straight in the output register so out_valid and data rise together.
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            sum_q       <= {fa_s, sum_sh_q[WIDTH-1:1]};
            cout_q      <= fa_c;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed-vector bench for serial_add_ctrl (WIDTH=8) with a queue-based result scoreboard.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];
  bit             ov_seen = 1'b0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one op and return #1 after the accept edge; 'hold' leaves in_valid high.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic cv, input logic sv, input logic [WIDTH:0] expv,
                      input bit hold);
    int n;
    a = av; b = bv; cin = cv;
`ifdef SERIAL_ADD_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub requested but not built in");
`endif
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(expv);
    acc_q.push_back(cyc);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_seen) begin
      ov_seen = 1'b1;
      if (acc_q.size() != 0) chk("latency", 64'(cyc - acc_q.pop_front()), 64'(WIDTH));
      else chk("latency_no_accept", 64'd1, 64'd0);
    end
    if (rst_n && out_valid && out_ready) begin
      ov_seen = 1'b0;
      if (exp_q.size() != 0) chk("result", 64'({cout, sum}), 64'(exp_q.pop_front()));
      else chk("unexpected_result", 64'({cout, sum}), 64'h1ff);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic             cv;
    logic [WIDTH:0]   expv;
  } vec_t;

  vec_t stream[4];
  int   prev_acc;

  initial begin
    stream[0] = '{8'h12, 8'h34, 1'b0, {1'b0, 8'h46}};
    stream[1] = '{8'h80, 8'h80, 1'b0, {1'b1, 8'h00}};
    stream[2] = '{8'hA5, 8'h5A, 1'b1, {1'b1, 8'h00}};
    stream[3] = '{8'h7F, 8'h01, 1'b1, {1'b0, 8'h81}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready_after_release", 64'(in_ready), 64'd1);

    // Basic add, carry chain, all-ones with cin
    send(8'h3C, 8'h55, 1'b0, 1'b0, {1'b0, 8'h91}, 1'b0);
    drain();
    send(8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 8'h00}, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0, {1'b1, 8'hFF}, 1'b0);
    drain();

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(8'h3C, 8'h55, 1'b0, 1'b0, {1'b0, 8'h91}, 1'b0);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_sum_stable", 64'(sum), 64'h91);
      chk("bp_cout_stable", 64'(cout), 64'd0);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_busy_high", 64'(busy), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Async reset mid-RUN aborts the op without any output
    send(8'h3C, 8'h55, 1'b0, 1'b0, {1'b0, 8'h91}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready_after_release", 64'(in_ready), 64'd1);
    send(8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 8'h02}, 1'b0);
    drain();

    // in_valid held high: back-to-back accepts every WIDTH+2 cycles
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      send(stream[i].av, stream[i].bv, stream[i].cv, 1'b0, stream[i].expv, 1'b1);
      if (i > 0) chk("stream_spacing", 64'(cyc - prev_acc), 64'(WIDTH + 2));
      prev_acc = cyc;
    end
    in_valid = 1'b0;
    drain();

`ifdef SERIAL_ADD_SUB_EN
    send(8'h10, 8'h01, 1'b0, 1'b1, {1'b1, 8'h0F}, 1'b0);
    send(8'h01, 8'h02, 1'b0, 1'b1, {1'b0, 8'hFF}, 1'b0);
    send(8'h3C, 8'h55, 1'b0, 1'b0, {1'b0, 8'h91}, 1'b0);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
